conv_ctrl_seq: RTL and testbench

Parametrised successor to the convolution unit controller. It owns the layer state machine instead of following an external state code, and tracks column, row and input-channel-pass position with counters. It generates accumulator clear and output-valid strobes, the scale select, and the row-buffer length mask. It sits between the top-level layer scheduler and the conv datapath (row buffers, multiplier array, adder tree).

---
 rtl/conv_ctrl_seq.sv | 174 +++++++++++++++++
 tb/tb_conv_ctrl_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_seq.sv
// Convolution layer controller: layer FSM, col/row/pass counters, accumulator and row-buffer strobes.
// Build option CONV_CTRL_ABORT_EN adds an `abort` input that cancels a running layer.
module conv_ctrl_seq #(
  parameter int ROW_BUFFER_DEPTH    = 9,
  parameter int MAX_HEIGHT_W        = 9,
  parameter int PASS_W              = 4,
  parameter int SCALE_WIDTH         = 4,
  parameter int MULT_PIPELINE_STAGE = 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [$clog2(ROW_BUFFER_DEPTH+1)-1:0] cfg_width,
  input  logic [MAX_HEIGHT_W-1:0]               cfg_height,
  input  logic [PASS_W-1:0]                     cfg_pass,
  input  logic [SCALE_WIDTH-1:0]                cfg_scale,
  input  logic                                  pix_valid,
`ifdef CONV_CTRL_ABORT_EN
  input  logic                                  abort,
`endif
  output logic [2:0]                            layer_state,
  output logic                                  busy,
  output logic                                  adder_rst,
  output logic                                  acc_out_valid,
  output logic [SCALE_WIDTH-1:0]                scale_in,
  output logic [ROW_BUFFER_DEPTH-1:0]           buff_len_ctrl,
  output logic                                  buff_len_rst,
  output logic                                  state_rst,
  output logic                                  done,
  output logic                                  cfg_err
);

  localparam int CW = $clog2(ROW_BUFFER_DEPTH + 1);
  localparam int DW = $clog2(MULT_PIPELINE_STAGE + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   state, nstate;
  logic [CW-1:0]                col, w_q;
  logic [MAX_HEIGHT_W-1:0]      row, h_q;
  logic [PASS_W-1:0]            pass, p_q;
  logic [DW-1:0]                drain_cnt;
  logic [MULT_PIPELINE_STAGE:0] win_dly;
  logic [ROW_BUFFER_DEPTH-1:0]  therm;
  logic abort_req, abort_hit, cfg_ok, beat, col_last, row_last, pass_last, win;
  logic launch, reject, pass_wrap;

`ifdef CONV_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // pix_valid is a beat strobe with no backpressure: every beat seen in FILL/RUN is consumed that cycle.
  assign beat      = pix_valid && (state == S_FILL || state == S_RUN);
  assign abort_hit = abort_req && (state != S_IDLE);
  assign cfg_ok    = (cfg_width >= CW'(3)) && (cfg_width <= CW'(ROW_BUFFER_DEPTH)) &&
                     (cfg_height >= MAX_HEIGHT_W'(3)) && (cfg_pass != '0);
  assign col_last  = (col == w_q - CW'(1));
  assign row_last  = (row == h_q - MAX_HEIGHT_W'(1));
  assign pass_last = (pass == p_q - PASS_W'(1));
  assign win       = beat && (state == S_RUN) && (col >= CW'(2)) && pass_last;

  assign layer_state   = state;
  assign acc_out_valid = win_dly[MULT_PIPELINE_STAGE];

  always_comb begin
    therm = '0;
    for (int i = 0; i < ROW_BUFFER_DEPTH; i++) therm[i] = (CW'(i) < cfg_width);
  end

  always_comb begin
    nstate    = state;
    launch    = 1'b0;
    reject    = 1'b0;
    pass_wrap = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort_req) begin
          if (cfg_ok) begin
            nstate = S_FILL;
            launch = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_FILL:  if (beat && col_last && row == MAX_HEIGHT_W'(1)) nstate = S_RUN;
      S_RUN: begin
        if (beat && col_last && row_last) begin
          if (pass_last) nstate = S_DRAIN;
          else begin
            nstate    = S_FILL;
            pass_wrap = 1'b1;
          end
        end
      end
      S_DRAIN: if (drain_cnt == DW'(MULT_PIPELINE_STAGE)) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
    if (abort_hit) nstate = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      adder_rst     <= 1'b0;
      scale_in      <= '0;
      buff_len_ctrl <= '0;
      buff_len_rst  <= 1'b0;
      state_rst     <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      win_dly       <= '0;
      drain_cnt     <= '0;
      col           <= '0;
      row           <= '0;
      pass          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      p_q           <= '0;
    end else begin
      state        <= nstate;
      busy         <= (nstate != S_IDLE);
      buff_len_rst <= launch || (pass_wrap && !abort_hit);
      cfg_err      <= reject;
      done         <= (nstate == S_DONE);
      state_rst    <= (nstate == S_DONE) || abort_hit;
      adder_rst    <= beat && (pass == '0) && !abort_hit;
      drain_cnt    <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;

      // Window flags walk the same depth as the multiplier/adder pipeline.
      win_dly[0] <= win && !abort_hit;
      for (int i = 1; i <= MULT_PIPELINE_STAGE; i++)
        win_dly[i] <= abort_hit ? 1'b0 : win_dly[i-1];

      if (launch) begin
        w_q           <= cfg_width;
        h_q           <= cfg_height;
        p_q           <= cfg_pass;
        scale_in      <= cfg_scale;
        buff_len_ctrl <= therm;
      end else if (nstate == S_DONE || abort_hit) begin
        scale_in      <= '0;
        buff_len_ctrl <= '0;
      end

      if (launch || abort_hit) begin
        col  <= '0;
        row  <= '0;
        pass <= '0;
      end else if (beat) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row  <= '0;
            pass <= pass + PASS_W'(1);
          end else begin
            row <= row + MAX_HEIGHT_W'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_ctrl_seq.sv
// Directed bench for conv_ctrl_seq: per-strobe expected-cycle queues checked by a negedge monitor.
// Abort scenario is compiled in when CONV_CTRL_ABORT_EN is defined.
module tb_conv_ctrl_seq;
  localparam int RBD = 9;
  localparam int HW  = 9;
  localparam int PW  = 4;
  localparam int SW  = 4;
  localparam int MPS = 2;
  localparam int CW  = 4;
  localparam int NK  = 6;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           start     = 1'b0;
  logic           pix_valid = 1'b0;
  logic [CW-1:0]  cfg_width = '0;
  logic [HW-1:0]  cfg_height = '0;
  logic [PW-1:0]  cfg_pass  = '0;
  logic [SW-1:0]  cfg_scale = '0;
`ifdef CONV_CTRL_ABORT_EN
  logic           abort     = 1'b0;
`endif
  logic [2:0]     layer_state;
  logic           busy, adder_rst, acc_out_valid, buff_len_rst, state_rst, done, cfg_err;
  logic [SW-1:0]  scale_in;
  logic [RBD-1:0] buff_len_ctrl;

  conv_ctrl_seq #(
    .ROW_BUFFER_DEPTH(RBD), .MAX_HEIGHT_W(HW), .PASS_W(PW),
    .SCALE_WIDTH(SW), .MULT_PIPELINE_STAGE(MPS)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pass(cfg_pass), .cfg_scale(cfg_scale),
    .pix_valid(pix_valid),
`ifdef CONV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .layer_state(layer_state), .busy(busy), .adder_rst(adder_rst), .acc_out_valid(acc_out_valid),
    .scale_in(scale_in), .buff_len_ctrl(buff_len_ctrl), .buff_len_rst(buff_len_rst),
    .state_rst(state_rst), .done(done), .cfg_err(cfg_err)
  );

  // scoreboard: one queue of expected pulse cycles per strobe
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[NK][$];
  int cnt[NK];
  logic [31:0] last_done = 0;
  logic [NK-1:0] pulses;
  assign pulses = {cfg_err, state_rst, done, buff_len_rst, acc_out_valid, adder_rst};

  function automatic string pname(input int i);
    case (i)
      0: return "adder_rst";
      1: return "acc_out_valid";
      2: return "buff_len_rst";
      3: return "done";
      4: return "state_rst";
      default: return "cfg_err";
    endcase
  endfunction

  initial for (int i = 0; i < NK; i++) cnt[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (pulses[i]) begin
        cnt[i]++;
        checks++;
        if (exp_q[i].size() != 0 && exp_q[i][0] == cyc) begin
          void'(exp_q[i].pop_front());
        end else begin
          errors++;
          $display("FAIL %s: pulse at cycle %0d, expected next at %0d (queue size %0d)",
                   pname(i), cyc, (exp_q[i].size() != 0) ? exp_q[i][0] : 32'hFFFF_FFFF, exp_q[i].size());
        end
      end else if (exp_q[i].size() != 0 && exp_q[i][0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: no pulse at cycle %0d, required at %0d", pname(i), cyc, exp_q[i][0]);
        void'(exp_q[i].pop_front());
      end
    end
    if (done) last_done = cyc;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] c);
    exp_q[k].push_back(c);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int p, input int s);
    cfg_width  = CW'(w);
    cfg_height = HW'(h);
    cfg_pass   = PW'(p);
    cfg_scale  = SW'(s);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, layer_state, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_scale"}, scale_in, 0);
    chk({tag, "_mask"}, buff_len_ctrl, 0);
  endtask

  task automatic run_layer(input int w, input int h, input int p, input int s, input bit toggle,
                           input int restart_beat, input logic [31:0] exp_mask,
                           input int n_add, input int n_acc, input int n_blr, input int exp_dur);
    logic [31:0] st, k;
    int c0[NK];
    int nb;
    for (int i = 0; i < NK; i++) c0[i] = cnt[i];
    st = cyc;
    push(2, st + 1);
    set_cfg(w, h, p, s);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_mask", buff_len_ctrl, exp_mask);
    chk("launch_scale", scale_in, s);
    chk("launch_busy", busy, 1);
    chk("launch_state", layer_state, 1);
    nb = 0;
    k = cyc;
    for (int pp = 0; pp < p; pp++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          k = cyc;
          if (pp == 0) push(0, k + 1);
          if (r >= 2 && c >= 2 && pp == p - 1) push(1, k + 3);
          if (c == w - 1 && r == h - 1 && pp != p - 1) push(2, k + 1);
          pix_valid = 1'b1;
          if (nb == restart_beat) begin
            set_cfg(9, 5, 3, 7);
            start = 1'b1;
          end
          tick();
          pix_valid = 1'b0;
          start = 1'b0;
          if (nb == restart_beat) begin
            chk("restart_mask", buff_len_ctrl, exp_mask);
            chk("restart_scale", scale_in, s);
            chk("restart_state", layer_state, 2);
          end
          if (toggle) tick();
          nb++;
        end
    push(3, k + 4);
    push(4, k + 4);
    repeat (6) tick();
    chk("duration", last_done - st, exp_dur);
    chk("n_adder_rst", cnt[0] - c0[0], n_add);
    chk("n_acc_out_valid", cnt[1] - c0[1], n_acc);
    chk("n_buff_len_rst", cnt[2] - c0[2], n_blr);
    chk("n_done", cnt[3] - c0[3], 1);
    chk("n_state_rst", cnt[4] - c0[4], 1);
    check_idle("post_layer");
  endtask

  task automatic bad_start(input int w, input int h, input int p);
    push(5, cyc + 1);
    set_cfg(w, h, p, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("reject");
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_adder_rst", adder_rst, 0);
    chk("reset_acc", acc_out_valid, 0);
    chk("reset_blr", buff_len_rst, 0);
    chk("reset_state_rst", state_rst, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_reset_state", layer_state, 0);

    // w, h, p, scale, toggle, restart_beat, mask, adder, acc, blr, done-start
    run_layer(4, 4, 1, 3, 1'b0, -1, 32'h00F, 16, 4, 1, 20);
    run_layer(3, 3, 2, 5, 1'b0, -1, 32'h007, 9, 1, 2, 22);
    run_layer(3, 3, 2, 5, 1'b1, -1, 32'h007, 9, 1, 2, 39);

    bad_start(2, 4, 1);
    bad_start(10, 4, 1);
    bad_start(4, 4, 0);
    bad_start(4, 2, 1);

    run_layer(4, 4, 1, 6, 1'b0, 12, 32'h00F, 16, 4, 1, 20);

    // reset dropped mid-RUN
    push(2, cyc + 1);
    set_cfg(4, 4, 1, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 9; b++) begin
      push(0, cyc + 1);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
    end
    chk("pre_reset_state", layer_state, 2);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_idle("async_reset");
    chk("async_reset_adder", adder_rst, 0);
    chk("async_reset_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) tick();
    chk("after_reset_state", layer_state, 0);

`ifdef CONV_CTRL_ABORT_EN
    push(2, cyc + 1);
    set_cfg(3, 3, 1, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 9; b++) begin
      push(0, cyc + 1);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
    end
    chk("abort_pre_state", layer_state, 3);
    push(4, cyc + 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", layer_state, 0);
    chk("abort_state_rst", state_rst, 1);
    chk("abort_done", done, 0);
    chk("abort_scale", scale_in, 0);
    repeat (6) tick();
    set_cfg(4, 4, 1, 3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_state", layer_state, 0);
    chk("abort_start_blr", buff_len_rst, 0);
    repeat (3) tick();
`endif

    repeat (5) tick();
    for (int i = 0; i < NK; i++) chk({"pending_", pname(i)}, exp_q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
